eth_phy_10g_rx_prbs31_check: RTL and testbench

Receive-side PRBS31 checker for the 10G PHY. It is the counterpart of the transmit PRBS31 generator that runs when cfg_tx_prbs31_enable is set. It watches raw 66-bit blocks from the SERDES (hdr + data) in the rx_clk domain, self-synchronises to the pattern, and reports a per-block bit-error count, a saturating running total and a lock flag. It sits beside the 64b/66b receive path and feeds the rx_error_count status.

---
 rtl/eth_phy_10g_rx_prbs31_check_if.sv | 25 ++
 rtl/eth_phy_10g_rx_prbs31_check.sv | 179 +++++++++++++++++
 tb/tb_eth_phy_10g_rx_prbs31_check.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_phy_10g_rx_prbs31_check_if.sv
// Raw SERDES receive block bus feeding the PRBS31 checker.
//   serdes_rx_data  : block payload, data[0] is the first payload bit on the line
//   serdes_rx_hdr   : sync header, hdr[0] is the first bit of the block on the line
//   serdes_rx_valid : a block is present this cycle
// master drives the bus (SERDES side), slave samples it (checker side).
interface eth_phy_10g_rx_prbs31_check_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) ();
  logic [DATA_WIDTH-1:0] serdes_rx_data;
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
  logic                  serdes_rx_valid;

  modport master (
    output serdes_rx_data,
    output serdes_rx_hdr,
    output serdes_rx_valid
  );

  modport slave (
    input serdes_rx_data,
    input serdes_rx_hdr,
    input serdes_rx_valid
  );
endinterface

// File: rtl/eth_phy_10g_rx_prbs31_check.sv
// Receive-side inverted-PRBS31 (x^31 + x^28 + 1) checker for the 10G PHY.
// Self-synchronising: every received bit is predicted from the 28th and 31st
// bits before it in the received stream, so no seed exchange is needed.
// Ports:
//   rx_clk, rx_rst          : clock, synchronous active-high reset
//   cfg_rx_prbs31_enable    : checker enable; low forces DISABLED
//   rx_if (slave)           : raw 66-bit blocks (hdr + data) with valid
//   clear_counters          : synchronous clear of the running total
//   prbs_block_error_count  : bit errors in the last checked block (0..66)
//   prbs_error_total        : saturating total, accumulated only while locked
//   prbs_error              : one-cycle pulse per checked block with errors
//   prbs_locked             : lock flag
module eth_phy_10g_rx_prbs31_check #(
  parameter int DATA_WIDTH       = 64,
  parameter int HDR_WIDTH        = 2,
  parameter int ERR_CNT_WIDTH    = 32,
  parameter int LOCK_GOOD_BLOCKS = 64,
  parameter int LOSS_BAD_BLOCKS  = 16
) (
  input  logic                               rx_clk,
  input  logic                               rx_rst,
  input  logic                               cfg_rx_prbs31_enable,
  eth_phy_10g_rx_prbs31_check_if.slave       rx_if,
  input  logic                               clear_counters,
  output logic [6:0]                         prbs_block_error_count,
  output logic [ERR_CNT_WIDTH-1:0]           prbs_error_total,
  output logic                               prbs_error,
  output logic                               prbs_locked
);

  localparam int BLK_W  = HDR_WIDTH + DATA_WIDTH;
  localparam int HIST_W = 31;
  localparam int EXT_W  = BLK_W + HIST_W;
  localparam int SUM_W  = ERR_CNT_WIDTH + 1;
  localparam int GOOD_W = $clog2(LOCK_GOOD_BLOCKS + 1);
  localparam int BAD_W  = $clog2(LOSS_BAD_BLOCKS + 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_FILL,
    ST_HUNT,
    ST_LOCKED
  } state_e;

  state_e                     state_q, state_d;
  logic [HIST_W-1:0]          hist_q, hist_d;
  logic [GOOD_W-1:0]          good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]           bad_cnt_q, bad_cnt_d;
  logic [6:0]                 blk_cnt_q, blk_cnt_d;
  logic [ERR_CNT_WIDTH-1:0]   total_q, total_d;
  logic                       error_q, error_d;
  logic                       locked_q, locked_d;

  // Stream order: bit 0 is hdr[0], bit 1 is hdr[1], bit 2.. are data[0..].
  logic [BLK_W-1:0]           blk;
  logic [EXT_W-1:0]           ext;
  logic [BLK_W-1:0]           err_bits;
  logic [6:0]                 blk_cnt;
  logic [SUM_W-1:0]           total_sum;
  logic [ERR_CNT_WIDTH-1:0]   total_sat;

  assign blk = {rx_if.serdes_rx_data, rx_if.serdes_rx_hdr};
  // hist_q[0] is the oldest remembered bit (b[-31]), hist_q[30] is b[-1],
  // so ext[i + 31] is b[i] for every i including negative ones.
  assign ext = {blk, hist_q};
  // e[i] = ~(b[i] ^ b[i-28] ^ b[i-31]) for all bits of the block at once.
  assign err_bits = ~(ext[EXT_W-1:HIST_W] ^ ext[BLK_W+2:3] ^ ext[BLK_W-1:0]);

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here and below via defaults first), otherwise a latch is inferred.
  always_comb begin
    blk_cnt = '0;
    for (int i = 0; i < BLK_W; i++) begin
      blk_cnt = blk_cnt + 7'(err_bits[i]);
    end
  end

  assign total_sum = {1'b0, total_q} + SUM_W'(blk_cnt);
  assign total_sat = total_sum[ERR_CNT_WIDTH] ? '1 : total_sum[ERR_CNT_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    total_d    = total_q;
    locked_d   = locked_q;
    blk_cnt_d  = '0;
    error_d    = 1'b0;

    if (!cfg_rx_prbs31_enable) begin
      state_d    = ST_DISABLED;
      hist_d     = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      locked_d   = 1'b0;
    end else if (rx_if.serdes_rx_valid) begin
      hist_d = blk[BLK_W-1:BLK_W-HIST_W];
      unique case (state_q)
        // Enabled while still DISABLED behaves as FILL, so the very first
        // block after enable seeds the history.
        ST_DISABLED, ST_FILL: begin
          state_d    = ST_HUNT;
          good_cnt_d = '0;
        end
        ST_HUNT: begin
          blk_cnt_d = blk_cnt;
          error_d   = |blk_cnt;
          if (blk_cnt == '0) begin
            if (good_cnt_q == GOOD_W'(LOCK_GOOD_BLOCKS - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              bad_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          blk_cnt_d = blk_cnt;
          error_d   = |blk_cnt;
          total_d   = total_sat;
          if (blk_cnt != '0) begin
            if (bad_cnt_q == BAD_W'(LOSS_BAD_BLOCKS - 1)) begin
              state_d    = ST_HUNT;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              locked_d   = 1'b0;
            end else begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end else if (state_q == ST_DISABLED) begin
      state_d = ST_FILL;
    end

    // Clear beats a coincident add: that block's errors are dropped.
    if (clear_counters) begin
      total_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q    <= ST_DISABLED;
      hist_q     <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      total_q    <= '0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      total_q    <= total_d;
      error_q    <= error_d;
      locked_q   <= locked_d;
    end
  end

  assign prbs_block_error_count = blk_cnt_q;
  assign prbs_error_total       = total_q;
  assign prbs_error             = error_q;
  assign prbs_locked            = locked_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_prbs31_check.sv
// Bench for eth_phy_10g_rx_prbs31_check. Two instances share one stimulus bus:
// dut_a uses default parameters, dut_b has an 8-bit total and a loss threshold
// of 1000. A behavioural model (bit queues, plain counters) predicts every
// output each cycle; literal expectations pin the key scenarios.
module tb_eth_phy_10g_rx_prbs31_check;

  logic rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  logic rx_rst, en, clr;
  eth_phy_10g_rx_prbs31_check_if rx_bus ();

  logic [6:0]  a_cnt, b_cnt;
  logic [31:0] a_total;
  logic [7:0]  b_total;
  logic        a_err, b_err, a_locked, b_locked;

  eth_phy_10g_rx_prbs31_check dut_a (
    .rx_clk                 (rx_clk),
    .rx_rst                 (rx_rst),
    .cfg_rx_prbs31_enable   (en),
    .rx_if                  (rx_bus),
    .clear_counters         (clr),
    .prbs_block_error_count (a_cnt),
    .prbs_error_total       (a_total),
    .prbs_error             (a_err),
    .prbs_locked            (a_locked)
  );

  eth_phy_10g_rx_prbs31_check #(
    .ERR_CNT_WIDTH   (8),
    .LOSS_BAD_BLOCKS (1000)
  ) dut_b (
    .rx_clk                 (rx_clk),
    .rx_rst                 (rx_rst),
    .cfg_rx_prbs31_enable   (en),
    .rx_if                  (rx_bus),
    .clear_counters         (clr),
    .prbs_block_error_count (b_cnt),
    .prbs_error_total       (b_total),
    .prbs_error             (b_err),
    .prbs_locked            (b_locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_OFF, M_FILL, M_HUNT, M_LOCK} phase_e;
  typedef struct {
    phase_e          phase;
    int              good;
    int              bad;
    longint unsigned total;
    bit              locked;
    int              count;
    bit              err;
  } model_t;

  model_t mA, mB;
  bit     mq[$];          // last 31 received stream bits, oldest first
  bit     started = 1'b0;

  // Count bits that break b[i] = ~(b[i-28] ^ b[i-31]).
  function automatic int model_errs(input bit h[$], input logic [65:0] s);
    bit x[97];
    int n = 0;
    for (int k = 0; k < 31; k++) x[k] = h[k];
    for (int i = 0; i < 66; i++) x[31 + i] = s[i];
    for (int i = 0; i < 66; i++) begin
      if (x[i + 31] == (x[i + 3] ^ x[i])) n++;
    end
    return n;
  endfunction

  function automatic model_t step(input model_t m, input bit r, input bit e, input bit v,
                                  input bit c, input int n, input int loss, input int width);
    longint unsigned cap = (64'd1 << width) - 1;
    if (r) begin
      m = '{M_OFF, 0, 0, 0, 1'b0, 0, 1'b0};
      return m;
    end
    m.count = 0;
    m.err   = 1'b0;
    if (!e) begin
      m.phase = M_OFF; m.good = 0; m.bad = 0; m.locked = 1'b0;
    end else if (!v) begin
      if (m.phase == M_OFF) m.phase = M_FILL;
    end else begin
      case (m.phase)
        M_OFF, M_FILL: begin m.phase = M_HUNT; m.good = 0; end
        M_HUNT: begin
          m.count = n; m.err = (n != 0);
          if (n == 0) begin
            m.good++;
            if (m.good == 64) begin m.phase = M_LOCK; m.locked = 1'b1; m.bad = 0; end
          end else m.good = 0;
        end
        M_LOCK: begin
          m.count = n; m.err = (n != 0);
          m.total = (m.total + n > cap) ? cap : m.total + n;
          if (n != 0) begin
            m.bad++;
            if (m.bad == loss) begin
              m.phase = M_HUNT; m.good = 0; m.bad = 0; m.locked = 1'b0;
            end
          end else m.bad = 0;
        end
        default: m.phase = M_OFF;
      endcase
    end
    if (c) m.total = 0;
    return m;
  endfunction

  always @(posedge rx_clk) begin
    logic [65:0] s;
    int          n;
    s  = {rx_bus.serdes_rx_data, rx_bus.serdes_rx_hdr};
    if (!started) begin
      mq.delete();
      for (int k = 0; k < 31; k++) mq.push_back(1'b0);
    end
    n  = model_errs(mq, s);
    mA = step(mA, rx_rst, en, rx_bus.serdes_rx_valid, clr, n, 16, 32);
    mB = step(mB, rx_rst, en, rx_bus.serdes_rx_valid, clr, n, 1000, 8);
    if (rx_rst || !en) begin
      for (int k = 0; k < 31; k++) mq[k] = 1'b0;
    end else if (rx_bus.serdes_rx_valid) begin
      for (int i = 0; i < 66; i++) begin
        mq.push_back(s[i]);
        void'(mq.pop_front());
      end
    end
    started = 1'b1;
  end

  always @(negedge rx_clk) begin
    if (started) begin
      check("a_count",  a_cnt,    64'(mA.count));
      check("a_error",  a_err,    64'(mA.err));
      check("a_locked", a_locked, 64'(mA.locked));
      check("a_total",  a_total,  mA.total);
      check("b_count",  b_cnt,    64'(mB.count));
      check("b_error",  b_err,    64'(mB.err));
      check("b_locked", b_locked, 64'(mB.locked));
      check("b_total",  b_total,  mB.total);
    end
  end

  // ---------------- stimulus ----------------
  bit gq[$];   // generator history, last 31 transmitted bits, oldest first

  function automatic logic [65:0] gen_clean();
    logic [65:0] s;
    bit          nb;
    for (int i = 0; i < 66; i++) begin
      nb = ~(gq[3] ^ gq[0]);
      s[i] = nb;
      gq.push_back(nb);
      void'(gq.pop_front());
    end
    return s;
  endfunction

  function automatic logic [65:0] rand_blk();
    return {$urandom(), $urandom(), 2'($urandom())};
  endfunction

  // Drive one cycle of inputs, return at the next falling edge with outputs
  // reflecting the block just sampled.
  task automatic send(input bit v, input logic [65:0] s, input bit c);
    rx_bus.serdes_rx_valid = v;
    rx_bus.serdes_rx_hdr   = s[1:0];
    rx_bus.serdes_rx_data  = s[65:2];
    clr                    = c;
    @(negedge rx_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] s;
    int          n, guard;

    for (int k = 0; k < 31; k++) gq.push_back(1'($urandom()));
    rx_rst = 1'b1; en = 1'b0; clr = 1'b0;
    send(1'b0, '0, 1'b0);
    send(1'b0, '0, 1'b0);
    check("reset_count",  a_cnt, 0);
    check("reset_locked", a_locked, 0);
    check("reset_total",  a_total, 0);

    // 1: clean stream from enable, block 0 fills, 64 HUNT blocks lock.
    rx_rst = 1'b0; en = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      send(1'b1, gen_clean(), 1'b0);
      if (k == 0)  check("t1_fill_count", a_cnt, 0);
      if (k == 63) check("t1_not_locked_yet", a_locked, 0);
      if (k == 64) check("t1_locked_cycle65", a_locked, 1);
    end
    check("t1_total", a_total, 0);
    for (int k = 0; k < 4; k++) send(1'b1, gen_clean(), 1'b0);

    // 2: single flip at stream index 12 -> errors at 12, 40, 43.
    s = gen_clean(); s[12] = ~s[12];
    send(1'b1, s, 1'b0);
    check("t2_count", a_cnt, 3);
    check("t2_error", a_err, 1);
    check("t2_total", a_total, 3);
    send(1'b1, gen_clean(), 1'b0);
    check("t2_error_one_cycle", a_err, 0);
    check("t2_locked_held", a_locked, 1);

    // 3: flip at index 65 -> 1 error here, 2 in the next block (27, 30).
    s = gen_clean(); s[65] = ~s[65];
    send(1'b1, s, 1'b0);
    check("t3_count_first", a_cnt, 1);
    send(1'b1, gen_clean(), 1'b0);
    check("t3_count_second", a_cnt, 2);
    check("t3_total", a_total, 6);
    send(1'b1, gen_clean(), 1'b0);
    check("t3_clean_after", a_cnt, 0);

    // 4: 16 garbage blocks drop lock on dut_a; relock with idle gaps.
    for (int j = 0; j < 16; j++) begin
      send(1'b1, rand_blk(), 1'b0);
      if (j == 14) check("t4_locked_after_15", a_locked, 1);
      if (j == 15) check("t4_unlocked_after_16", a_locked, 0);
    end
    n = 0; guard = 0;
    while (a_locked !== 1'b1 && guard < 400) begin
      if ($urandom_range(0, 2) == 0) send(1'b0, rand_blk(), 1'b0);
      else begin
        send(1'b1, gen_clean(), 1'b0);
        n++;
      end
      guard++;
    end
    check("t4_relocked", a_locked, 1);
    // The first clean block is judged against garbage history, then 64 clean.
    check("t4_relock_blocks", 64'(n), 65);
    check("t4_b_never_lost_lock", b_locked, 1);

    // 5: 8-bit total saturates at 255 under all-zero blocks (66 errors each
    // once history is zero; all-ones is a fixed point of the recurrence).
    send(1'b0, '0, 1'b1);
    check("t5_clear_b", b_total, 0);
    for (int j = 0; j < 6; j++) send(1'b1, '0, 1'b0);
    check("t5_b_saturated", b_total, 255);
    send(1'b1, '0, 1'b0);
    check("t5_b_stays_saturated", b_total, 255);
    check("t5_b_locked", b_locked, 1);

    // 6: clear wins over add; disable holds total; re-enable refills.
    send(1'b1, '0, 1'b1);
    check("t6_clear_wins", a_total, 0);
    check("t6_count_max", a_cnt, 66);
    check("t6_lock_unaffected", a_locked, 1);
    send(1'b1, '0, 1'b0);
    check("t6_total_66", a_total, 66);
    en = 1'b0;
    send(1'b1, '0, 1'b0);
    check("t6_disabled_unlocked", a_locked, 0);
    check("t6_disabled_total_held", a_total, 66);
    en = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      send(1'b1, gen_clean(), 1'b0);
      if (k == 0)  check("t6_fill_count", a_cnt, 0);
      if (k == 63) check("t6_not_locked_yet", a_locked, 0);
      if (k == 64) check("t6_relocked", a_locked, 1);
    end
    check("t6_total_still_held", a_total, 66);

    // Reset mid-operation.
    rx_rst = 1'b1;
    send(1'b1, gen_clean(), 1'b0);
    check("rst_mid_locked", a_locked, 0);
    check("rst_mid_total", a_total, 0);
    rx_rst = 1'b0;
    send(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
